// File: rtl/ddr_pkg.sv
// Shared constants for the BRAM<->DDR FIFO bridge: MIG command codes, FSM encodings, tag width.
package ddr_pkg;

  localparam logic [2:0] APP_CMD_WR = 3'b000;
  localparam logic [2:0] APP_CMD_RD = 3'b001;

  localparam logic [1:0] S_CAL  = 2'd0;
  localparam logic [1:0] S_IDLE = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_RD   = 2'd3;

  localparam int unsigned TAG_W = 8;

  typedef logic [TAG_W-1:0] tag_t;

endpackage

// File: rtl/ddr_tag_queue.sv
// Synchronous FIFO of read tags, one entry per read still in flight at the MIG.
module ddr_tag_queue
  import ddr_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk_100,
  input  logic                   rst_n,
  input  logic                   push,
  input  tag_t                   push_tag,
  input  logic                   pop,
  output tag_t                   head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  tag_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk_100) begin
    if (push) mem[wr_ptr] <= push_tag;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/ddr_mig_req_bridge.sv
// Drains the request FIFO into single-beat MIG commands and returns tagged read data
// into the response FIFO.
module ddr_mig_req_bridge
  import ddr_pkg::*;
#(
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned REQ_ADDR_W = 25,
  parameter int unsigned APP_ADDR_W = 28,
  parameter int unsigned ADDR_SHIFT = 3,
  parameter int unsigned MAX_OUTST  = 16
) (
  input  logic                        clk_100,
  input  logic                        rst_n,
  input  logic                        init_calib_complete,
  input  logic                        req_empty,
  input  logic [REQ_ADDR_W+DATA_W:0]  req_dout,
  output logic                        req_rd_en,
  input  logic                        rsp_almost_full,
  output logic                        rsp_wr_en,
  output logic [TAG_W+DATA_W-1:0]     rsp_din,
  output logic [APP_ADDR_W-1:0]       app_addr,
  output logic [2:0]                  app_cmd,
  output logic                        app_en,
  input  logic                        app_rdy,
  output logic [DATA_W-1:0]           app_wdf_data,
  output logic                        app_wdf_wren,
  output logic                        app_wdf_end,
  input  logic                        app_wdf_rdy,
  input  logic [DATA_W-1:0]           app_rd_data,
  input  logic                        app_rd_data_valid,
  output logic [$clog2(MAX_OUTST):0]  outstanding,
  output logic                        err_unexp_rd
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTST) + 1;

  logic                             req_we;
  logic [REQ_ADDR_W-1:0]            req_addr;
  logic [DATA_W-1:0]                req_data;
  logic [REQ_ADDR_W+ADDR_SHIFT-1:0] addr_shifted;

  logic [1:0]            state_q, state_d;
  logic                  cmd_ok_q, cmd_ok_d;
  logic                  dat_ok_q, dat_ok_d;
  logic                  app_en_d, app_wdf_wren_d;
  logic [2:0]            app_cmd_d;
  logic [APP_ADDR_W-1:0] app_addr_d;
  logic [DATA_W-1:0]     app_wdf_data_d;

  logic cmd_hs, dat_hs, wr_done, rd_issue, rd_pop;
  tag_t tag_head;
  logic [CNT_W-1:0] tag_count;
  logic tag_empty, tag_full;

  assign {req_we, req_addr, req_data} = req_dout;
  assign addr_shifted = {req_addr, {ADDR_SHIFT{1'b0}}};

  assign cmd_hs   = app_en & app_rdy;
  assign dat_hs   = app_wdf_wren & app_wdf_rdy;
  assign wr_done  = (state_q == S_WR) & (cmd_ok_q | cmd_hs) & (dat_ok_q | dat_hs);
  assign rd_issue = (state_q == S_RD) & cmd_hs;
  assign rd_pop   = app_rd_data_valid & (outstanding != '0);

  // Pop lands in the handshake cycle, so the FWFT head stays put for the whole command.
  assign req_rd_en   = wr_done | rd_issue;
  assign app_wdf_end = app_wdf_wren;

  always_comb begin
    state_d        = state_q;
    cmd_ok_d       = cmd_ok_q;
    dat_ok_d       = dat_ok_q;
    app_en_d       = app_en;
    app_cmd_d      = app_cmd;
    app_addr_d     = app_addr;
    app_wdf_data_d = app_wdf_data;
    app_wdf_wren_d = app_wdf_wren;
    unique case (state_q)
      S_CAL: begin
        if (init_calib_complete) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (!req_empty) begin
          if (req_we) begin
            app_addr_d     = APP_ADDR_W'(addr_shifted);
            app_wdf_data_d = req_data;
            app_cmd_d      = APP_CMD_WR;
            app_en_d       = 1'b1;
            app_wdf_wren_d = 1'b1;
            cmd_ok_d       = 1'b0;
            dat_ok_d       = 1'b0;
            state_d        = S_WR;
          end else if (!rsp_almost_full && (outstanding < CNT_W'(MAX_OUTST))) begin
            app_addr_d = APP_ADDR_W'(addr_shifted);
            app_cmd_d  = APP_CMD_RD;
            app_en_d   = 1'b1;
            state_d    = S_RD;
          end
        end
      end
      S_WR: begin
        if (cmd_hs) begin
          app_en_d = 1'b0;
          cmd_ok_d = 1'b1;
        end
        if (dat_hs) begin
          app_wdf_wren_d = 1'b0;
          dat_ok_d       = 1'b1;
        end
        if (wr_done) state_d = S_IDLE;
      end
      S_RD: begin
        if (cmd_hs) begin
          app_en_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_CAL;
    endcase
  end

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_CAL;
      cmd_ok_q     <= 1'b0;
      dat_ok_q     <= 1'b0;
      app_en       <= 1'b0;
      app_cmd      <= '0;
      app_addr     <= '0;
      app_wdf_data <= '0;
      app_wdf_wren <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_ok_q     <= cmd_ok_d;
      dat_ok_q     <= dat_ok_d;
      app_en       <= app_en_d;
      app_cmd      <= app_cmd_d;
      app_addr     <= app_addr_d;
      app_wdf_data <= app_wdf_data_d;
      app_wdf_wren <= app_wdf_wren_d;
    end
  end

  // Read return path runs regardless of FSM state; stray data gets tag 0 and flags an error.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      rsp_wr_en    <= 1'b0;
      rsp_din      <= '0;
      outstanding  <= '0;
      err_unexp_rd <= 1'b0;
    end else begin
      rsp_wr_en <= app_rd_data_valid;
      if (app_rd_data_valid) begin
        rsp_din <= {(rd_pop ? tag_head : tag_t'('0)), app_rd_data};
        if (!rd_pop) err_unexp_rd <= 1'b1;
      end
      case ({rd_issue, rd_pop})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  ddr_tag_queue #(
    .DEPTH (MAX_OUTST)
  ) u_tag_queue (
    .clk_100  (clk_100),
    .rst_n    (rst_n),
    .push     (rd_issue),
    .push_tag (req_addr[TAG_W-1:0]),
    .pop      (rd_pop),
    .head     (tag_head),
    .count    (tag_count),
    .empty    (tag_empty),
    .full     (tag_full)
  );

  a_count_match: assert property (@(posedge clk_100) disable iff (!rst_n)
    tag_count == outstanding);
  a_no_overflow: assert property (@(posedge clk_100) disable iff (!rst_n)
    !(rd_issue && tag_full) && !(rd_pop && tag_empty));

endmodule

// File: tb/tb_ddr_mig_req_bridge.sv
// Randomized bench for ddr_mig_req_bridge: emulates the request FIFO and the MIG, and scores
// commands, pops, responses and the outstanding count against a queue-based model.
module tb_ddr_mig_req_bridge;
  import ddr_pkg::*;

  localparam int unsigned DATA_W     = 128;
  localparam int unsigned REQ_ADDR_W = 25;
  localparam int unsigned APP_ADDR_W = 28;
  localparam int unsigned ADDR_SHIFT = 3;
  localparam int unsigned MAX_OUTST  = 16;

  typedef struct packed {
    logic                  we;
    logic [REQ_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } req_t;

  typedef struct packed {
    logic [7:0]  tag;
    int unsigned due;
  } mig_t;

  logic                       clk_100 = 1'b0;
  logic                       rst_n = 1'b0;
  logic                       init_calib_complete = 1'b0;
  logic                       req_empty = 1'b1;
  logic [REQ_ADDR_W+DATA_W:0] req_dout = '0;
  logic                       req_rd_en;
  logic                       rsp_almost_full = 1'b0;
  logic                       rsp_wr_en;
  logic [TAG_W+DATA_W-1:0]    rsp_din;
  logic [APP_ADDR_W-1:0]      app_addr;
  logic [2:0]                 app_cmd;
  logic                       app_en;
  logic                       app_rdy = 1'b0;
  logic [DATA_W-1:0]          app_wdf_data;
  logic                       app_wdf_wren;
  logic                       app_wdf_end;
  logic                       app_wdf_rdy = 1'b0;
  logic [DATA_W-1:0]          app_rd_data = '0;
  logic                       app_rd_data_valid = 1'b0;
  logic [$clog2(MAX_OUTST):0] outstanding;
  logic                       err_unexp_rd;

  always #5 clk_100 = ~clk_100;

  ddr_mig_req_bridge #(
    .DATA_W     (DATA_W),
    .REQ_ADDR_W (REQ_ADDR_W),
    .APP_ADDR_W (APP_ADDR_W),
    .ADDR_SHIFT (ADDR_SHIFT),
    .MAX_OUTST  (MAX_OUTST)
  ) dut (
    .clk_100             (clk_100),
    .rst_n               (rst_n),
    .init_calib_complete (init_calib_complete),
    .req_empty           (req_empty),
    .req_dout            (req_dout),
    .req_rd_en           (req_rd_en),
    .rsp_almost_full     (rsp_almost_full),
    .rsp_wr_en           (rsp_wr_en),
    .rsp_din             (rsp_din),
    .app_addr            (app_addr),
    .app_cmd             (app_cmd),
    .app_en              (app_en),
    .app_rdy             (app_rdy),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_rd_data         (app_rd_data),
    .app_rd_data_valid   (app_rd_data_valid),
    .outstanding         (outstanding),
    .err_unexp_rd        (err_unexp_rd)
  );

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Environment knobs
  req_t req_q[$];
  mig_t mig_q[$];
  int   rdy_pct = 100, wdf_pct = 100, lat_min = 1, lat_max = 1;
  bit   af = 0, hold_ret = 0, ret_on_issue = 0, stray = 0;
  int unsigned cyc = 0;

  // Reference model and statistics
  int   m_out, prev_out;
  bit   m_err, rsp_pend, cmd_done, dat_done, drop_en, drop_wren, prev_en, prev_af;
  logic [TAG_W+DATA_W-1:0] rsp_exp;
  int   n_wdf = 0, n_wr_cmd = 0, n_rd_cmd = 0, n_rsp = 0, n_dut_pop = 0, peak = 0;
  logic [7:0] tags_seen[$];

  task automatic drive_req();
    req_empty = (req_q.size() == 0);
    req_dout  = req_empty ? '0 : req_q[0];
  endtask

  task automatic push_req(input bit we, input logic [REQ_ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] data);
    req_t r;
    r.we = we; r.addr = addr; r.data = data;
    req_q.push_back(r);
    drive_req();
  endtask

  task automatic model_clear();
    mig_q.delete();
    m_out = 0; prev_out = 0; m_err = 0; rsp_pend = 0; cmd_done = 0; dat_done = 0;
    drop_en = 0; drop_wren = 0; prev_en = 0; prev_af = 0;
    app_rd_data_valid = 1'b0; app_rdy = 1'b0; app_wdf_rdy = 1'b0;
  endtask

  task automatic check_reset_outs(input string tag);
    check_eq({tag, "_ctl"}, {app_en, app_wdf_wren, app_wdf_end, req_rd_en, rsp_wr_en,
                             err_unexp_rd}, 6'b0);
    check_eq({tag, "_addr"}, app_addr, '0);
    check_eq({tag, "_cmd"}, app_cmd, '0);
    check_eq({tag, "_wdata"}, app_wdf_data, '0);
    check_eq({tag, "_rsp"}, rsp_din, '0);
    check_eq({tag, "_outst"}, outstanding, '0);
  endtask

  // One clock: check registered state, drive MIG side, predict the edge, advance.
  task automatic step();
    bit ret, do_pop, issue, exp_pop, cmd_hs, dat_hs;
    logic [7:0] rtag;
    mig_t m;
    @(negedge clk_100);
    check_eq("rsp_wr_en", rsp_wr_en, rsp_pend);
    if (rsp_pend) begin
      check_eq("rsp_din", rsp_din, rsp_exp);
      n_rsp++;
      tags_seen.push_back(rsp_din[DATA_W +: TAG_W]);
    end
    check_eq("outstanding", outstanding, m_out);
    check_eq("err_unexp_rd", err_unexp_rd, m_err);
    check_eq("wdf_end", app_wdf_end, app_wdf_wren);
    if (drop_en) check_eq("en_drop", app_en, 1'b0);
    if (drop_wren) check_eq("wren_drop", app_wdf_wren, 1'b0);
    if (int'(outstanding) > peak) peak = int'(outstanding);
    if (app_en && !prev_en) begin
      if (req_q.size() == 0) check_eq("cmd_no_req", app_en, 1'b0);
      else begin
        check_eq("app_addr", app_addr, APP_ADDR_W'(req_q[0].addr) << ADDR_SHIFT);
        check_eq("app_cmd", app_cmd, req_q[0].we ? APP_CMD_WR : APP_CMD_RD);
        check_eq("wren_start", app_wdf_wren, req_q[0].we);
        if (req_q[0].we) n_wr_cmd++;
        else begin
          n_rd_cmd++;
          check_eq("rd_gate", {prev_af, (prev_out < int'(MAX_OUTST))}, 2'b01);
        end
      end
    end
    prev_en = app_en;

    app_rdy         = ($urandom_range(99) < rdy_pct);
    app_wdf_rdy     = ($urandom_range(99) < wdf_pct);
    rsp_almost_full = af;
    ret = 0; rtag = 8'h00;
    if (stray) begin
      ret = 1; stray = 0;
    end else if (mig_q.size() != 0 && !hold_ret) begin
      if (ret_on_issue) ret = app_en && app_rdy && (app_cmd == APP_CMD_RD);
      else ret = (mig_q[0].due <= cyc);
    end
    if (ret && mig_q.size() != 0) begin
      rtag = mig_q[0].tag;
      void'(mig_q.pop_front());
    end
    app_rd_data_valid = ret;
    app_rd_data = {$urandom, $urandom, $urandom, $urandom};
    #1;

    cmd_hs = app_en && app_rdy;
    dat_hs = app_wdf_wren && app_wdf_rdy;
    issue  = 0;
    if (cmd_hs) cmd_done = 1;
    if (dat_hs) begin
      dat_done = 1;
      n_wdf++;
      if (req_q.size() != 0) check_eq("wdf_data", app_wdf_data, req_q[0].data);
    end
    exp_pop = 0;
    if (req_q.size() != 0) begin
      exp_pop = cmd_done && (dat_done || !req_q[0].we);
      issue   = cmd_hs && !req_q[0].we;
    end
    check_eq("req_rd_en", req_rd_en, exp_pop);
    if (req_rd_en) n_dut_pop++;
    if (issue) begin
      m.tag = req_q[0].addr[7:0];
      m.due = cyc + $urandom_range(lat_max, lat_min);
      mig_q.push_back(m);
    end
    do_pop   = ret && (m_out > 0);
    rsp_pend = ret;
    rsp_exp  = {(do_pop ? rtag : 8'h00), app_rd_data};
    if (ret && m_out == 0) m_err = 1;
    prev_af  = af;
    prev_out = m_out;
    m_out    = m_out + (issue ? 1 : 0) - (do_pop ? 1 : 0);
    drop_en   = cmd_hs;
    drop_wren = dat_hs;

    @(posedge clk_100);
    #1;
    cyc++;
    if (exp_pop) begin
      void'(req_q.pop_front());
      cmd_done = 0;
      dat_done = 0;
      drive_req();
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int w0, p0;
    bit seen;
    model_clear();
    drive_req();
    #3;
    check_reset_outs("reset");
    #19 rst_n = 1'b1;

    // Calibration gate, then first command two edges after calib rises
    push_req(1'b1, 25'h0000055, {4{32'hDEADBEEF}});
    for (int i = 0; i < 50; i++) begin
      step();
      check_eq("cal_hold_en", app_en, 1'b0);
    end
    init_calib_complete = 1'b1;
    step();
    check_eq("cal_edge1_en", app_en, 1'b0);
    step();
    check_eq("cal_edge2_en", app_en, 1'b1);
    run(6);

    // Write with delayed command accept, immediate data accept
    rdy_pct = 0; wdf_pct = 100;
    push_req(1'b1, 25'h0000123, {16{8'hA5}});
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      seen = app_en;
    end
    check_eq("wr_cmd_seen", seen, 1'b1);
    check_eq("wr_app_addr", app_addr, 28'h0000918);
    w0 = n_wdf; p0 = n_dut_pop;
    run(3);
    check_eq("wr_wdf_once", n_wdf - w0, 1);
    check_eq("wr_no_pop_yet", n_dut_pop - p0, 0);
    rdy_pct = 100;
    step();
    check_eq("wr_pop_once", n_dut_pop - p0, 1);
    run(4);
    check_eq("wr_wdf_total", n_wdf - w0, 1);
    check_eq("wr_pop_total", n_dut_pop - p0, 1);

    // Eight reads with fixed 20-cycle MIG latency
    lat_min = 20; lat_max = 20; peak = 0; n_rsp = 0; tags_seen.delete();
    for (int i = 0; i < 8; i++) push_req(1'b0, 25'h00001F0 + 25'(i), '0);
    run(70);
    check_eq("rd8_count", n_rsp, 8);
    for (int i = 0; i < 8; i++)
      if (i < tags_seen.size()) check_eq("rd8_tag", tags_seen[i], 8'hF0 + 8'(i));
    check_eq("rd8_peak", peak, 8);
    check_eq("rd8_outst_end", outstanding, '0);

    // Almost-full blocks reads but not writes
    lat_min = 1; lat_max = 5; af = 1;
    w0 = n_wr_cmd;
    push_req(1'b1, 25'h1ABCDEF, {4{32'h0BADF00D}});
    run(10);
    check_eq("af_wr_issued", n_wr_cmd - w0, 1);
    p0 = n_rd_cmd;
    for (int i = 0; i < 4; i++) push_req(1'b0, 25'h0000300 + 25'(i), '0);
    run(20);
    check_eq("af_rd_blocked", n_rd_cmd - p0, 0);
    af = 0;
    run(30);
    check_eq("af_rd_released", n_rd_cmd - p0, 4);

    // Simultaneous issue and return at outstanding=3, then a stray return
    hold_ret = 1;
    for (int i = 0; i < 3; i++) push_req(1'b0, 25'h0000410 + 25'(i), '0);
    run(12);
    check_eq("coinc_pre", outstanding, 3);
    hold_ret = 0; ret_on_issue = 1;
    push_req(1'b0, 25'h0000420, '0);
    run(8);
    check_eq("coinc_post", outstanding, 3);
    ret_on_issue = 0; lat_min = 1; lat_max = 3;
    run(20);
    check_eq("coinc_drained", outstanding, '0);
    stray = 1;
    step();
    check_eq("stray_err", err_unexp_rd, 1'b1);
    check_eq("stray_rsp", rsp_wr_en, 1'b1);
    check_eq("stray_tag", rsp_din[DATA_W +: TAG_W], 8'h00);
    check_eq("stray_outst", outstanding, '0);
    run(3);

    // Asynchronous reset in the middle of a write
    rdy_pct = 0; wdf_pct = 0;
    push_req(1'b1, 25'h0000777, {4{32'h12345678}});
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      seen = app_en;
    end
    check_eq("rst_wr_seen", seen, 1'b1);
    p0 = n_dut_pop;
    rst_n = 1'b0;
    #1;
    check_reset_outs("rst_mid");
    model_clear();
    init_calib_complete = 1'b0;
    @(negedge clk_100);
    rst_n = 1'b1;
    rdy_pct = 100; wdf_pct = 100;
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("rst_cal_en", app_en, 1'b0);
    end
    check_eq("rst_no_pop", n_dut_pop - p0, 0);
    init_calib_complete = 1'b1;
    step();
    check_eq("rst_cal_edge1", app_en, 1'b0);
    step();
    check_eq("rst_cal_edge2", app_en, 1'b1);

    // Randomized traffic
    lat_min = 1; lat_max = 40;
    for (int i = 0; i < 1500; i++) begin
      rdy_pct = 70; wdf_pct = 60;
      af = ($urandom_range(9) == 0);
      if (req_q.size() < 6 && $urandom_range(99) < 40)
        push_req(1'($urandom_range(1)), 25'($urandom_range(33554431)),
                 {$urandom, $urandom, $urandom, $urandom});
      step();
    end
    af = 0; rdy_pct = 100; wdf_pct = 100;
    for (int i = 0; i < 600; i++) begin
      if (req_q.size() == 0 && mig_q.size() == 0 && m_out == 0 && !rsp_pend) break;
      step();
    end
    check_eq("drain_req", req_q.size(), 0);
    check_eq("drain_outst", outstanding, '0);
    run(2);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
